// File: rtl/dat_mem_mover_if.sv
// Bundle of the mover's command/status signals and its data-memory port.
`default_nettype none

interface dat_mem_mover_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
);
    logic          start;
    logic          op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [DW-1:0] fill_val;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    modport master (
        input  start, op, src, dst, len, fill_val, mem_rdata,
        output mem_addr, mem_wdata, mem_rd_en, mem_wr_en, busy, done, checksum
    );

    modport slave (
        output start, op, src, dst, len, fill_val, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en, busy, done, checksum
    );
endinterface

`default_nettype wire

// File: rtl/dat_mem_mover.sv
// Block COPY / FILL engine for the data-memory port, with a running byte checksum.
`default_nettype none

module dat_mem_mover #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dat_mem_mover_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          op_fill;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] cnt;
    logic [DW-1:0] data_byte;
    logic [DW-1:0] sum;
    logic [AW-1:0] cur_addr;
    logic          rd;
    logic          wr;
    logic          busy_flag;
    logic          done_flag;

    // Outputs are driven straight from registers; the write data register
    // holds the fill value (FILL) or the byte captured in RD (COPY).
    assign bus.mem_addr  = cur_addr;
    assign bus.mem_wdata = data_byte;
    assign bus.mem_rd_en = rd;
    assign bus.mem_wr_en = wr;
    assign bus.busy      = busy_flag;
    assign bus.done      = done_flag;
    assign bus.checksum  = sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_fill   <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            cnt       <= '0;
            data_byte <= '0;
            sum       <= '0;
            cur_addr  <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_fill   <= bus.op;
                        src_ptr   <= bus.src;
                        dst_ptr   <= bus.dst;
                        cnt       <= bus.len;
                        data_byte <= bus.fill_val;
                        sum       <= '0;
                        if (bus.len == '0) begin
                            state     <= DONE;
                            done_flag <= 1'b1;
                        end else if (!bus.op) begin
                            state     <= RD;
                            cur_addr  <= bus.src;
                            rd        <= 1'b1;
                            busy_flag <= 1'b1;
                        end else begin
                            state     <= WR;
                            cur_addr  <= bus.dst;
                            wr        <= 1'b1;
                            busy_flag <= 1'b1;
                        end
                    end
                end
                RD: begin
                    data_byte <= bus.mem_rdata;
                    state     <= WR;
                    cur_addr  <= dst_ptr;
                    rd        <= 1'b0;
                    wr        <= 1'b1;
                end
                WR: begin
                    sum     <= sum + data_byte;
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                    cnt     <= cnt - LW'(1);
                    if (cnt == LW'(1)) begin
                        state     <= DONE;
                        wr        <= 1'b0;
                        busy_flag <= 1'b0;
                        done_flag <= 1'b1;
                    end else if (!op_fill) begin
                        state    <= RD;
                        cur_addr <= src_ptr + AW'(1);
                        rd       <= 1'b1;
                        wr       <= 1'b0;
                    end else begin
                        cur_addr <= dst_ptr + AW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dat_mem_mover.sv
// Directed self-checking bench for dat_mem_mover with a 256-byte memory model.
`default_nettype none

module tb_dat_mem_mover;

    logic clk;
    logic reset;

    dat_mem_mover_if bus ();

    dat_mem_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    int         n_cmp;
    int         n_err;
    int         both_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en)
            mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    initial both_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_rd_en && bus.mem_wr_en)
            both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    // lat counts clock edges from the accepting edge (=1) to the one after
    // which done is seen; glitch>0 re-pulses start with other args that cycle.
    task automatic run_op(input logic o, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input int glitch,
                          output int lat, output int busy_cyc, output int act,
                          output int dones);
        int cyc;
        lat = 0; busy_cyc = 0; act = 0; dones = 0;
        @(negedge clk);
        bus.op = o; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = f;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (bus.busy) busy_cyc++;
            if (bus.mem_rd_en || bus.mem_wr_en) act++;
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = cyc;
            end
            if (cyc == glitch) begin
                bus.op = ~o; bus.src = 8'h55; bus.dst = 8'h90; bus.len = 8'd7;
                bus.fill_val = 8'hEE; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (lat != 0 && cyc >= lat + 3) break;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int lat, bc, act, dn;
        n_cmp = 0; n_err = 0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.start = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_val = '0;
        reset = 1'b0;
        #12;
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_en", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'h0);
        chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("rst_sum", 32'(bus.checksum), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Plain COPY
        poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
        run_op(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, lat, bc, act, dn);
        chk("copy_lat", 32'(lat), 32'd9);
        chk("copy_busy", 32'(bc), 32'd8);
        chk("copy_act", 32'(act), 32'd8);
        chk("copy_dones", 32'(dn), 32'd1);
        chk("copy_sum", 32'(bus.checksum), 32'h0A);
        for (int i = 0; i < 4; i++)
            chk("copy_mem", 32'(mem[8'h80 + i]), 32'(i + 1));

        // FILL wrapping past 0xFF
        run_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5, 0, lat, bc, act, dn);
        chk("fill_lat", 32'(lat), 32'd5);
        chk("fill_busy", 32'(bc), 32'd4);
        chk("fill_sum", 32'(bus.checksum), 32'h94);
        chk("fill_mem_fe", 32'(mem[8'hFE]), 32'hA5);
        chk("fill_mem_ff", 32'(mem[8'hFF]), 32'hA5);
        chk("fill_mem_00", 32'(mem[8'h00]), 32'hA5);
        chk("fill_mem_01", 32'(mem[8'h01]), 32'hA5);

        // Zero-length, both ops
        run_op(1'b0, 8'h10, 8'h30, 8'd0, 8'h00, 0, lat, bc, act, dn);
        chk("len0c_lat", 32'(lat), 32'd1);
        chk("len0c_act", 32'(act), 32'd0);
        chk("len0c_sum", 32'(bus.checksum), 32'h0);
        run_op(1'b1, 8'h10, 8'h30, 8'd0, 8'h77, 0, lat, bc, act, dn);
        chk("len0f_lat", 32'(lat), 32'd1);
        chk("len0f_act", 32'(act), 32'd0);
        chk("len0f_busy", 32'(bc), 32'd0);

        // Overlapping COPY replicates the first byte
        poke(8'h20, 8'h11); poke(8'h21, 8'h22); poke(8'h22, 8'h00); poke(8'h23, 8'h00);
        run_op(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 0, lat, bc, act, dn);
        chk("ovl_lat", 32'(lat), 32'd7);
        chk("ovl_sum", 32'(bus.checksum), 32'h33);
        chk("ovl_mem21", 32'(mem[8'h21]), 32'h11);
        chk("ovl_mem22", 32'(mem[8'h22]), 32'h11);
        chk("ovl_mem23", 32'(mem[8'h23]), 32'h11);

        // start while busy must be ignored
        poke(8'h90, 8'h00);
        run_op(1'b0, 8'h10, 8'hA0, 8'd4, 8'h00, 2, lat, bc, act, dn);
        chk("busy_lat", 32'(lat), 32'd9);
        chk("busy_dones", 32'(dn), 32'd1);
        chk("busy_sum", 32'(bus.checksum), 32'h0A);
        chk("busy_mem_a0", 32'(mem[8'hA0]), 32'h01);
        chk("busy_mem_a3", 32'(mem[8'hA3]), 32'h04);
        chk("busy_mem_90", 32'(mem[8'h90]), 32'h00);

        // Reset after three FILL writes
        poke(8'h40, 8'h00); poke(8'h42, 8'h00); poke(8'h43, 8'h00);
        @(negedge clk);
        bus.op = 1'b1; bus.dst = 8'h40; bus.len = 8'd10; bus.fill_val = 8'h5A;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'h0);
        chk("abort_en", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'h0);
        chk("abort_addr", 32'(bus.mem_addr), 32'h0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort_dones", 32'(dn), 32'd0);
        chk("abort_mem42", 32'(mem[8'h42]), 32'h5A);
        chk("abort_mem43", 32'(mem[8'h43]), 32'h00);
        reset = 1'b1;
        run_op(1'b1, 8'h00, 8'h60, 8'd2, 8'h07, 0, lat, bc, act, dn);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_sum", 32'(bus.checksum), 32'h0E);
        chk("post_mem61", 32'(mem[8'h61]), 32'h07);

        chk("rd_wr_excl", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
